// File: rtl/cpu_instr_sequencer.sv
// Program-side driver for the 8-bit CPU core: buffers a small program, issues one
// instruction word per 4-clock slot and captures the core's result once per slot.
module cpu_instr_sequencer #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int IW     = 13,
  parameter int DW     = 8,
  parameter int PHASES = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] cpu_result,
  output logic [IW-1:0] instr,
  output logic          cpu_rst,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic [DW-1:0] result,
  output logic          result_valid,
  output logic          done
);

  localparam int            PW      = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(PHASES - 1);
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [IW-1:0] mem_q [DEPTH];
  logic          mem_we;

  logic [1:0]    state_q,   state_d;
  logic [AW:0]   len_q,     len_d;
  logic [AW-1:0] pc_q,      pc_d;
  logic [PW-1:0] phase_q,   phase_d;
  logic          cap_q,     cap_d;
  logic [IW-1:0] instr_q,   instr_d;
  logic          cpu_rst_q, cpu_rst_d;
  logic          busy_q,    busy_d;
  logic [DW-1:0] result_q,  result_d;
  logic          rv_q,      rv_d;
  logic          done_q,    done_d;
  logic          pc_last;

  assign pc_last = ({1'b0, pc_q} == (len_q - (AW+1)'(1'b1)));

  // Next-state logic for the issue/capture sequence.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    pc_d      = pc_q;
    phase_d   = phase_q;
    cap_d     = cap_q;
    instr_d   = instr_q;
    cpu_rst_d = cpu_rst_q;
    busy_d    = busy_q;
    result_d  = result_q;
    rv_d      = 1'b0;
    done_d    = 1'b0;
    mem_we    = 1'b0;

    // Result of the previous slot is sampled one clock after its phase-3 edge.
    if (cap_q) begin
      result_d = cpu_result;
      rv_d     = 1'b1;
      cap_d    = 1'b0;
    end else begin
      rv_d     = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        mem_we = load_en;
        if (start && (prog_len != {(AW+1){1'b0}})) begin
          len_d     = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
          instr_d   = mem_q[{AW{1'b0}}];
          pc_d      = {AW{1'b0}};
          phase_d   = {PW{1'b0}};
          cpu_rst_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_RUN;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d   = S_IDLE;
          cpu_rst_d = 1'b1;
          instr_d   = {IW{1'b0}};
          phase_d   = {PW{1'b0}};
          cap_d     = 1'b0;
          busy_d    = 1'b0;
          rv_d      = 1'b0;
          result_d  = result_q;
        end else if (phase_q == PH_LAST) begin
          phase_d = {PW{1'b0}};
          cap_d   = 1'b1;
          if (pc_last) begin
            state_d = S_DRAIN;
          end else begin
            pc_d    = pc_q + AW'(1'b1);
            instr_d = mem_q[pc_q + AW'(1'b1)];
          end
        end else begin
          phase_d = phase_q + PW'(1'b1);
        end
      end
      S_DRAIN: begin
        cpu_rst_d = 1'b1;
        instr_d   = {IW{1'b0}};
        busy_d    = 1'b0;
        phase_d   = {PW{1'b0}};
        state_d   = S_IDLE;
        if (abort) begin
          cap_d    = 1'b0;
          rv_d     = 1'b0;
          result_d = result_q;
        end else begin
          done_d   = 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        cpu_rst_d = 1'b1;
        instr_d   = {IW{1'b0}};
        phase_d   = {PW{1'b0}};
        cap_d     = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // Program buffer: deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[load_addr] <= load_data;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      len_q     <= {(AW+1){1'b0}};
      pc_q      <= {AW{1'b0}};
      phase_q   <= {PW{1'b0}};
      cap_q     <= 1'b0;
      instr_q   <= {IW{1'b0}};
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      result_q  <= {DW{1'b0}};
      rv_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      pc_q      <= pc_d;
      phase_q   <= phase_d;
      cap_q     <= cap_d;
      instr_q   <= instr_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      result_q  <= result_d;
      rv_q      <= rv_d;
      done_q    <= done_d;
    end
  end

  assign instr        = instr_q;
  assign cpu_rst      = cpu_rst_q;
  assign pc           = pc_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = rv_q;
  assign done         = done_q;

endmodule

// File: tb/tb_cpu_instr_sequencer.sv
// Self-checking bench for cpu_instr_sequencer: table-driven runs, hand-written
// reset sequence and randomized runs against a per-cycle behavioural model.
module tb_cpu_instr_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int IW    = 13;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [IW-1:0] load_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic          abort;
  logic [DW-1:0] cpu_result;
  logic [IW-1:0] instr;
  logic          cpu_rst;
  logic [AW-1:0] pc;
  logic          busy;
  logic [DW-1:0] result;
  logic          result_valid;
  logic          done;

  always #5 clk = ~clk;

  cpu_instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .IW(IW), .DW(DW), .PHASES(4)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .prog_len(prog_len), .start(start), .abort(abort),
    .cpu_result(cpu_result), .instr(instr), .cpu_rst(cpu_rst), .pc(pc),
    .busy(busy), .result(result), .result_valid(result_valid), .done(done)
  );

  typedef struct {
    int         plen;
    int         abort_at;
    bit         abort_with_start;
    int         exp_len;
    logic [7:0] r0;
  } vec_t;

  vec_t          vecs [9];
  logic [IW-1:0] model_buf [DEPTH];
  logic [DW-1:0] exp_result;
  int            n_chk  = 0;
  int            n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (time %0t)", name, act, exp, $time);
  endtask

  task automatic load_word(input int addr, input logic [IW-1:0] data);
    load_en   = 1'b1;
    load_addr = AW'(addr);
    load_data = data;
    @(negedge clk);
    load_en = 1'b0;
    model_buf[addr] = data;
  endtask

  // Sample t follows edge Et, E0 being the start edge; abort_at is the edge index that sees abort.
  task automatic run_prog(input int plen, input int abort_at, input bit ab_start,
                          input int len, input logic [7:0] r0);
    logic [DW-1:0] res [DEPTH];
    int last_t;
    int slot;
    for (int j = 0; j < DEPTH; j++) res[j] = 8'(int'(r0) + 17 * j);
    start      = 1'b1;
    prog_len   = (AW+1)'(plen);
    abort      = ab_start;
    load_en    = 1'b0;
    cpu_result = 8'($urandom);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    if (len == 0) begin
      for (int k = 0; k < 3; k++) begin
        chk("ignored_start_busy", busy, 0);
        chk("ignored_start_cpu_rst", cpu_rst, 1);
        chk("ignored_start_instr", instr, 0);
        chk("ignored_start_rv", result_valid, 0);
        @(negedge clk);
      end
      return;
    end
    last_t = (abort_at != 0) ? abort_at : 4 * len + 1;
    for (int t = 0; t <= last_t; t++) begin
      if (t < last_t) begin
        slot = (t / 4 < len) ? t / 4 : len - 1;
        chk("run_busy", busy, 1);
        chk("run_cpu_rst", cpu_rst, 0);
        chk("run_instr", instr, model_buf[slot]);
        chk("run_pc", pc, slot);
        chk("run_done", done, 0);
        if (t >= 5 && t % 4 == 1) begin
          exp_result = res[(t - 5) / 4];
          chk("run_rv", result_valid, 1);
        end else begin
          chk("run_rv", result_valid, 0);
        end
        chk("run_result", result, exp_result);
      end else begin
        chk("end_busy", busy, 0);
        chk("end_cpu_rst", cpu_rst, 1);
        chk("end_instr", instr, 0);
        if (abort_at == 0) begin
          exp_result = res[len - 1];
          chk("end_rv", result_valid, 1);
          chk("end_done", done, 1);
        end else begin
          chk("abort_rv", result_valid, 0);
          chk("abort_done", done, 0);
        end
        chk("end_result", result, exp_result);
      end
      if (t < last_t) begin
        // Noise that must be ignored while busy, including overwrites of word 0.
        start      = 1'($urandom);
        prog_len   = (AW+1)'($urandom);
        load_en    = 1'($urandom);
        load_addr  = ($urandom % 2 == 0) ? AW'(0) : AW'($urandom);
        load_data  = ($urandom % 2 == 0) ? 13'h1FFF : IW'($urandom);
        abort      = (t + 1 == abort_at);
        cpu_result = (t >= 4 && t % 4 == 0 && t / 4 - 1 < len) ? res[t / 4 - 1] : 8'($urandom);
        @(negedge clk);
      end else begin
        start   = 1'b0;
        load_en = 1'b0;
        abort   = 1'b0;
      end
    end
  endtask

  initial begin
    int plen, len, ab;
    vecs[0] = '{1,  0, 1'b0, 1,  8'h2A};
    vecs[1] = '{3,  0, 1'b0, 3,  8'h11};
    vecs[2] = '{0,  0, 1'b0, 0,  8'h00};
    vecs[3] = '{20, 0, 1'b0, 16, 8'h40};
    vecs[4] = '{3,  7, 1'b0, 3,  8'h51};
    vecs[5] = '{3,  0, 1'b1, 3,  8'h60};
    vecs[6] = '{2,  9, 1'b0, 2,  8'h70};
    vecs[7] = '{16, 0, 1'b0, 16, 8'h05};
    vecs[8] = '{4,  1, 1'b0, 4,  8'h90};

    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    prog_len = '0; start = 1'b0; abort = 1'b0; cpu_result = '0;
    exp_result = '0;
    #2;
    chk("reset_instr", instr, 0);
    chk("reset_cpu_rst", cpu_rst, 1);
    chk("reset_pc", pc, 0);
    chk("reset_busy", busy, 0);
    chk("reset_result", result, 0);
    chk("reset_rv", result_valid, 0);
    chk("reset_done", done, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int a = 0; a < DEPTH; a++) begin
      if (a == 0)      load_word(a, 13'h0205);
      else if (a == 1) load_word(a, 13'h0403);
      else if (a == 2) load_word(a, 13'h0019);
      else             load_word(a, IW'($urandom));
    end

    for (int i = 0; i < 9; i++)
      run_prog(vecs[i].plen, vecs[i].abort_at, vecs[i].abort_with_start,
               vecs[i].exp_len, vecs[i].r0);

    // Asynchronous reset in the middle of a run, then a rerun from the retained buffer.
    start = 1'b1; prog_len = 5'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("midrun_reset_instr", instr, 0);
    chk("midrun_reset_cpu_rst", cpu_rst, 1);
    chk("midrun_reset_busy", busy, 0);
    chk("midrun_reset_rv", result_valid, 0);
    chk("midrun_reset_result", result, 0);
    exp_result = '0;
    @(negedge clk);
    reset = 1'b0;
    run_prog(3, 0, 1'b0, 3, 8'hA1);

    for (int r = 0; r < 20; r++) begin
      if ($urandom % 3 == 0)
        for (int k = 0; k < 3; k++) load_word($urandom_range(0, DEPTH - 1), IW'($urandom));
      plen = $urandom_range(0, 20);
      len  = (plen > DEPTH) ? DEPTH : plen;
      ab   = (len > 0 && $urandom % 3 == 0) ? $urandom_range(1, 4 * len + 1) : 0;
      run_prog(plen, ab, ($urandom % 4 == 0), len, 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
